// File: rtl/ft245_model_pkg.sv
// Shared types and constants for the FT245 device-side bus model.
// Protocol error flags are built only with FT245_MODEL_PROTOCHK_EN.
package ft245_model_pkg;

  localparam int BYTE_W = 8;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_RD_WAIT  = 3'd1;
  localparam state_t ST_RD_DRIVE = 3'd2;
  localparam state_t ST_RD_PRE   = 3'd3;
  localparam state_t ST_WR_HOLD  = 3'd4;
  localparam state_t ST_WR_PRE   = 3'd5;

  localparam int ERR_RD   = 0;
  localparam int ERR_WR   = 1;
  localparam int ERR_BOTH = 2;

  // Down-counters stop at zero, so a span of n cycles loads n-1.
  function automatic logic [7:0] cnt_load(input int n);
    return (n > 0) ? 8'(n - 1) : 8'd0;
  endfunction

endpackage

// File: rtl/ft245_model_queue.sv
// Synchronous FIFO with registered count/full/empty and
// combinational head read; one instance per transfer direction.
module ft245_model_queue
  import ft245_model_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = BYTE_W
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   i_push,
  input  logic [W-1:0]           i_din,
  input  logic                   i_pop,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count,
  output logic [W-1:0]           o_head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_full;
  logic          r_empty;

  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_count_nxt;

  assign w_push      = i_push && !r_full;
  assign w_pop       = i_pop && !r_empty;
  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CW'(DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= i_din;
  end

  assign o_full  = r_full;
  assign o_empty = r_empty;
  assign o_count = r_count;
  assign o_head  = r_mem[r_rptr];

endmodule

// File: rtl/ft245_device_model.sv
// FTDI-side FT245 async FIFO bus model with host byte-stream ports.
// Define FT245_MODEL_PROTOCHK_EN to build the sticky err_o flags.
module ft245_device_model
  import ft245_model_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int RD_LAT  = 2,
  parameter int RXF_PRE = 3,
  parameter int TXE_PRE = 3
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   nRD_i,
  input  logic                   nWR_i,
  input  logic [BYTE_W-1:0]      data_i,
  output logic [BYTE_W-1:0]      data_o,
  output logic                   data_oe_o,
  output logic                   nRXF_o,
  output logic                   nTXE_o,
  input  logic                   host_tx_valid_i,
  output logic                   host_tx_ready_o,
  input  logic [BYTE_W-1:0]      host_tx_data_i,
  output logic                   host_rx_valid_o,
  input  logic                   host_rx_ready_i,
  output logic [BYTE_W-1:0]      host_rx_data_o,
  output logic [$clog2(DEPTH):0] rx_count_o,
  output logic [$clog2(DEPTH):0] tx_count_o,
  output logic [2:0]             err_o
);

  localparam logic [7:0] LD_RD  = cnt_load(RD_LAT);
  localparam logic [7:0] LD_RXF = cnt_load(RXF_PRE);
  localparam logic [7:0] LD_TXE = cnt_load(TXE_PRE);

  state_t      r_state;
  state_t      w_nxt;
  logic [7:0]  r_cnt;
  logic [7:0]  w_cnt_nxt;
  logic        r_nrd_prev;
  logic        r_nwr_prev;
  logic        r_nrxf;
  logic        r_ntxe;
  logic        r_oe;
  logic [7:0]  r_data;
  logic        r_live;
  logic        w_nrxf_nxt;
  logic        w_ntxe_nxt;

  logic        w_rd_fall;
  logic        w_wr_fall;
  logic        w_rx_push;
  logic        w_rx_pop;
  logic        w_tx_push;
  logic        w_tx_pop;
  logic        w_rx_full;
  logic        w_rx_empty;
  logic        w_tx_full;
  logic        w_tx_empty;
  logic [7:0]  w_rx_head;

  assign w_rd_fall = !nRD_i && r_nrd_prev;
  assign w_wr_fall = !nWR_i && r_nwr_prev;

  assign w_rx_push = host_tx_valid_i && host_tx_ready_o;
  assign w_rx_pop  = (r_state == ST_RD_DRIVE) && nRD_i;
  assign w_tx_push = (r_state == ST_IDLE) && w_wr_fall
                     && !w_rd_fall && !r_ntxe;
  assign w_tx_pop  = host_rx_valid_o && host_rx_ready_i;

  ft245_model_queue #(.DEPTH(DEPTH), .W(BYTE_W)) u_rxq (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .i_push  (w_rx_push),
    .i_din   (host_tx_data_i),
    .i_pop   (w_rx_pop),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty),
    .o_count (rx_count_o),
    .o_head  (w_rx_head)
  );

  ft245_model_queue #(.DEPTH(DEPTH), .W(BYTE_W)) u_txq (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .i_push  (w_tx_push),
    .i_din   (data_i),
    .i_pop   (w_tx_pop),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty),
    .o_count (tx_count_o),
    .o_head  (host_rx_data_o)
  );

  always_comb begin
    w_nxt     = r_state;
    w_cnt_nxt = r_cnt;
    unique case (r_state)
      ST_IDLE: begin
        if (w_rd_fall && !w_wr_fall && !r_nrxf) begin
          w_nxt     = ST_RD_WAIT;
          w_cnt_nxt = LD_RD;
        end else if (w_tx_push) begin
          w_nxt = ST_WR_HOLD;
        end
      end
      ST_RD_WAIT: begin
        if (nRD_i) begin
          w_nxt     = ST_RD_PRE;
          w_cnt_nxt = LD_RXF;
        end else if (r_cnt == 8'd0) begin
          w_nxt = ST_RD_DRIVE;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      ST_RD_DRIVE: begin
        if (nRD_i) begin
          w_nxt     = ST_RD_PRE;
          w_cnt_nxt = LD_RXF;
        end
      end
      ST_WR_HOLD: begin
        if (nWR_i) begin
          w_nxt     = ST_WR_PRE;
          w_cnt_nxt = LD_TXE;
        end
      end
      ST_RD_PRE, ST_WR_PRE: begin
        if (r_cnt == 8'd0) w_nxt = ST_IDLE;
        else               w_cnt_nxt = r_cnt - 8'd1;
      end
      default: w_nxt = ST_IDLE;
    endcase
  end

  // Reads and writes are mutually exclusive: the idle flag
  // of the other direction is held high during a transfer.
  always_comb begin
    w_nrxf_nxt = 1'b1;
    w_ntxe_nxt = 1'b1;
    if (w_nxt == ST_IDLE) begin
      w_nrxf_nxt = w_rx_empty;
      w_ntxe_nxt = w_tx_full;
    end else if (w_nxt == ST_RD_WAIT || w_nxt == ST_RD_DRIVE) begin
      w_nrxf_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 8'd0;
      r_nrd_prev <= 1'b1;
      r_nwr_prev <= 1'b1;
      r_nrxf     <= 1'b1;
      r_ntxe     <= 1'b1;
      r_oe       <= 1'b0;
      r_data     <= 8'd0;
      r_live     <= 1'b0;
    end else begin
      r_state    <= w_nxt;
      r_cnt      <= w_cnt_nxt;
      r_nrd_prev <= nRD_i;
      r_nwr_prev <= nWR_i;
      r_nrxf     <= w_nrxf_nxt;
      r_ntxe     <= w_ntxe_nxt;
      r_oe       <= (w_nxt == ST_RD_DRIVE);
      r_live     <= 1'b1;
      if (r_state == ST_RD_WAIT && w_nxt == ST_RD_DRIVE)
        r_data <= w_rx_head;
    end
  end

`ifdef FT245_MODEL_PROTOCHK_EN
  logic [2:0] r_err;
  logic [2:0] w_err_set;

  always_comb begin
    w_err_set           = '0;
    w_err_set[ERR_BOTH] = w_rd_fall && w_wr_fall;
    w_err_set[ERR_WR]   = w_wr_fall && !w_rd_fall && r_ntxe;
    w_err_set[ERR_RD]   = w_rd_fall && !w_wr_fall && r_nrxf;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) r_err <= '0;
    else         r_err <= r_err | w_err_set;
  end

  assign err_o = r_err;
`else
  assign err_o = '0;
`endif

  assign data_o          = r_data;
  assign data_oe_o       = r_oe;
  assign nRXF_o          = r_nrxf;
  assign nTXE_o          = r_ntxe;
  assign host_tx_ready_o = r_live && !w_rx_full;
  assign host_rx_valid_o = !w_tx_empty;

endmodule

// File: tb/tb_ft245_device_model.sv
// Directed bench for ft245_device_model: op table plus corner
// sequences (overflow, abort, dual strobe, reset mid-read).
module tb_ft245_device_model;

  localparam int DEPTH  = 16;
  localparam int RD_LAT = 2;
  localparam int OP_PUSH  = 0;
  localparam int OP_READ  = 1;
  localparam int OP_WRITE = 2;
  localparam int OP_DRAIN = 3;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b1;
  logic       nRD_i = 1'b1;
  logic       nWR_i = 1'b1;
  logic [7:0] data_i = 8'h00;
  logic [7:0] data_o;
  logic       data_oe_o;
  logic       nRXF_o;
  logic       nTXE_o;
  logic       host_tx_valid_i = 1'b0;
  logic       host_tx_ready_o;
  logic [7:0] host_tx_data_i = 8'h00;
  logic       host_rx_valid_o;
  logic       host_rx_ready_i = 1'b0;
  logic [7:0] host_rx_data_o;
  logic [4:0] rx_count_o;
  logic [4:0] tx_count_o;
  logic [2:0] err_o;

  int n_checks = 0;
  int n_errors = 0;
  logic [2:0] exp_err = 3'b000;

  typedef struct {
    int         op;
    logic [7:0] d;
    int         rx;
    int         tx;
    logic       nrxf;
  } vec_t;

  vec_t vecs [10];

  ft245_device_model #(
    .DEPTH(DEPTH), .RD_LAT(RD_LAT), .RXF_PRE(3), .TXE_PRE(3)
  ) dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .nRD_i           (nRD_i),
    .nWR_i           (nWR_i),
    .data_i          (data_i),
    .data_o          (data_o),
    .data_oe_o       (data_oe_o),
    .nRXF_o          (nRXF_o),
    .nTXE_o          (nTXE_o),
    .host_tx_valid_i (host_tx_valid_i),
    .host_tx_ready_o (host_tx_ready_o),
    .host_tx_data_i  (host_tx_data_i),
    .host_rx_valid_o (host_rx_valid_o),
    .host_rx_ready_i (host_rx_ready_i),
    .host_rx_data_o  (host_rx_data_o),
    .rx_count_o      (rx_count_o),
    .tx_count_o      (tx_count_o),
    .err_o           (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic host_push(input logic [7:0] d);
    int n = 0;
    while (!host_tx_ready_o && n < 30) begin tick(); n++; end
    check("push_ready", host_tx_ready_o, 1);
    host_tx_valid_i = 1'b1;
    host_tx_data_i  = d;
    tick();
    host_tx_valid_i = 1'b0;
  endtask

  task automatic fpga_read(input logic [7:0] exp);
    int n = 0;
    while (nRXF_o && n < 30) begin tick(); n++; end
    check("rd_rxf_low", nRXF_o, 0);
    nRD_i = 1'b0;
    tick();
    n = 0;
    while (!data_oe_o && n < 20) begin tick(); n++; end
    check("rd_latency", n, RD_LAT);
    check("rd_data", data_o, exp);
    nRD_i = 1'b1;
    tick();
    check("rd_oe_off", data_oe_o, 0);
    check("rd_rxf_high", nRXF_o, 1);
  endtask

  task automatic fpga_write(input logic [7:0] d);
    int n = 0;
    while (nTXE_o && n < 30) begin tick(); n++; end
    check("wr_txe_low", nTXE_o, 0);
    nWR_i  = 1'b0;
    data_i = d;
    tick();
    nWR_i = 1'b1;
    tick();
  endtask

  task automatic host_drain(input logic [7:0] exp);
    int n = 0;
    while (!host_rx_valid_o && n < 30) begin tick(); n++; end
    check("drain_valid", host_rx_valid_o, 1);
    check("drain_data", host_rx_data_o, exp);
    host_rx_ready_i = 1'b1;
    tick();
    host_rx_ready_i = 1'b0;
  endtask

  initial begin
    logic seen;
    int   n;

    vecs[0] = '{OP_PUSH,  8'h50, 1, 0, 1'b0};
    vecs[1] = '{OP_PUSH,  8'h51, 2, 0, 1'b0};
    vecs[2] = '{OP_PUSH,  8'h52, 3, 0, 1'b0};
    vecs[3] = '{OP_READ,  8'h50, 2, 0, 1'b0};
    vecs[4] = '{OP_READ,  8'h51, 1, 0, 1'b0};
    vecs[5] = '{OP_READ,  8'h52, 0, 0, 1'b1};
    vecs[6] = '{OP_WRITE, 8'h31, 0, 1, 1'b1};
    vecs[7] = '{OP_WRITE, 8'h32, 0, 2, 1'b1};
    vecs[8] = '{OP_DRAIN, 8'h31, 0, 1, 1'b1};
    vecs[9] = '{OP_DRAIN, 8'h32, 0, 0, 1'b1};

    tick();
    tick();
    check("rst_nrxf", nRXF_o, 1);
    check("rst_ntxe", nTXE_o, 1);
    check("rst_oe", data_oe_o, 0);
    check("rst_data", data_o, 0);
    check("rst_rxcnt", rx_count_o, 0);
    check("rst_txcnt", tx_count_o, 0);
    check("rst_hvalid", host_rx_valid_o, 0);
    check("rst_hready", host_tx_ready_o, 0);
    check("rst_err", err_o, 0);
    reset_i = 1'b0;
    repeat (3) tick();
    check("idle_ntxe", nTXE_o, 0);
    check("idle_nrxf", nRXF_o, 1);
    check("idle_hready", host_tx_ready_o, 1);

    for (int i = 0; i < 10; i++) begin
      unique case (vecs[i].op)
        OP_PUSH:  host_push(vecs[i].d);
        OP_READ:  fpga_read(vecs[i].d);
        OP_WRITE: fpga_write(vecs[i].d);
        default:  host_drain(vecs[i].d);
      endcase
      repeat (6) tick();
      check("vec_rxcnt", rx_count_o, vecs[i].rx);
      check("vec_txcnt", tx_count_o, vecs[i].tx);
      check("vec_nrxf", nRXF_o, vecs[i].nrxf);
      check("vec_ntxe", nTXE_o, 0);
    end

    // Write held in the TX queue while host is not ready.
    nWR_i  = 1'b0;
    data_i = 8'h31;
    tick();
    check("wr_hold_cnt", tx_count_o, 1);
    check("wr_hold_valid", host_rx_valid_o, 1);
    check("wr_hold_data", host_rx_data_o, 8'h31);
    check("wr_hold_ntxe", nTXE_o, 1);
    nWR_i = 1'b1;
    repeat (6) tick();
    check("wr_hold_still", host_rx_valid_o, 1);
    host_drain(8'h31);
    check("wr_drained_cnt", tx_count_o, 0);
    check("wr_drained_valid", host_rx_valid_o, 0);

    // Fill the TX queue, then overflow.
    for (int i = 0; i < DEPTH; i++) fpga_write(8'(i + 16));
    repeat (6) tick();
    check("full_cnt", tx_count_o, DEPTH);
    check("full_ntxe", nTXE_o, 1);
    nWR_i  = 1'b0;
    data_i = 8'hFF;
    tick();
    nWR_i = 1'b1;
    repeat (6) tick();
`ifdef FT245_MODEL_PROTOCHK_EN
    exp_err[1] = 1'b1;
`endif
    check("ovf_cnt", tx_count_o, DEPTH);
    check("ovf_ntxe", nTXE_o, 1);
    check("ovf_err", err_o, exp_err);
    for (int i = 0; i < DEPTH; i++) host_drain(8'(i + 16));
    repeat (4) tick();
    check("drain_all_cnt", tx_count_o, 0);
    check("drain_all_ntxe", nTXE_o, 0);

    // Read aborted during the latency window.
    host_push(8'h77);
    repeat (6) tick();
    nRD_i = 1'b0;
    tick();
    nRD_i = 1'b1;
    seen = data_oe_o;
    repeat (8) begin tick(); seen = seen | data_oe_o; end
    check("abort_no_oe", seen, 0);
    check("abort_rxcnt", rx_count_o, 1);
    check("abort_nrxf", nRXF_o, 0);
    check("abort_err", err_o, exp_err);
    fpga_read(8'h77);
    repeat (6) tick();
    check("abort_after_rx", rx_count_o, 0);

    // Both strobes falling together.
    host_push(8'h88);
    repeat (6) tick();
    nRD_i  = 1'b0;
    nWR_i  = 1'b0;
    data_i = 8'hEE;
    tick();
    nRD_i = 1'b1;
    nWR_i = 1'b1;
    repeat (6) tick();
`ifdef FT245_MODEL_PROTOCHK_EN
    exp_err[2] = 1'b1;
`endif
    check("both_rxcnt", rx_count_o, 1);
    check("both_txcnt", tx_count_o, 0);
    check("both_oe", data_oe_o, 0);
    check("both_err", err_o, exp_err);
    fpga_read(8'h88);
    repeat (6) tick();

    // Reset while driving read data.
    host_push(8'h99);
    host_push(8'h9A);
    repeat (6) tick();
    nRD_i = 1'b0;
    tick();
    n = 0;
    while (!data_oe_o && n < 20) begin tick(); n++; end
    check("rst_pre_oe", data_oe_o, 1);
    check("rst_pre_data", data_o, 8'h99);
    reset_i = 1'b1;
    #1;
    check("rst_mid_oe", data_oe_o, 0);
    check("rst_mid_nrxf", nRXF_o, 1);
    check("rst_mid_rxcnt", rx_count_o, 0);
    check("rst_mid_txcnt", tx_count_o, 0);
    check("rst_mid_err", err_o, 0);
    nRD_i = 1'b1;
    tick();
    reset_i = 1'b0;
    repeat (4) tick();
    check("post_rst_nrxf", nRXF_o, 1);
    check("post_rst_oe", data_oe_o, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
